// File: rtl/ew_spi_reg_bank.sv
// ew_spi_reg_bank: register bank written by address+data frames over a slow,
// asynchronous 3-wire SPI (csb/sclk/mosi), with immediate or deferred
// (shadow + commit) update of the live registers.
module ew_spi_reg_bank #(
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_VALUE = '0,
  localparam int unsigned NUM_REGS   = 2**ADDR_W
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_spi_csb,
  input  logic                         i_spi_sclk,
  input  logic                         i_spi_mosi,
  input  logic                         i_defer,
  input  logic                         i_commit,
  input  logic                         i_regs_enb,
  output logic [NUM_REGS*DATA_W-1:0]   o_regs,
  output logic [NUM_REGS-1:0]          o_dirty,
  output logic                         o_busy,
  output logic                         o_frame_done,
  output logic                         o_frame_err
);

  localparam int unsigned FRAME_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
  localparam int unsigned BANK_W  = NUM_REGS * DATA_W;
  localparam logic [BANK_W-1:0] BANK_RESET = {NUM_REGS{RESET_VALUE}};

  logic [SYNC_STAGES-1:0] csb_sync_q,  csb_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES:0]   vld_q,       vld_d;
  logic                   csb_hist_q,  csb_hist_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   armed_q,     armed_d;
  logic [CNT_W-1:0]       cnt_q,       cnt_d;
  logic [FRAME_W-1:0]     shift_q,     shift_d;
  logic [BANK_W-1:0]      live_q,      live_d;
  logic [BANK_W-1:0]      shadow_q,    shadow_d;
  logic [NUM_REGS-1:0]    dirty_q,     dirty_d;
  logic                   done_q,      done_d;
  logic                   err_q,       err_d;

  logic               csb_s, sclk_s, mosi_s;
  logic               csb_fall, csb_rise, sclk_rise;
  logic [ADDR_W-1:0]  frame_addr;
  logic [DATA_W-1:0]  frame_data;

  // Synchroniser chains, edge history and a reset-fill tracker. A falling csb
  // only arms once both compared samples are real post-reset samples, so a
  // csb held low across reset release is never mistaken for a new frame.
  always_comb begin
    csb_sync_d  = {csb_sync_q[SYNC_STAGES-2:0],  i_spi_csb};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_spi_sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
    vld_d       = {vld_q[SYNC_STAGES-1:0], 1'b1};
    csb_s       = csb_sync_q[SYNC_STAGES-1];
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    csb_hist_d  = csb_s;
    sclk_hist_d = sclk_s;
    csb_fall    = vld_q[SYNC_STAGES] & csb_hist_q & ~csb_s;
    csb_rise    = ~csb_hist_q & csb_s;
    sclk_rise   = ~sclk_hist_q & sclk_s;
    frame_addr  = shift_q[FRAME_W-1 -: ADDR_W];
    frame_data  = shift_q[DATA_W-1:0];
  end

  // Frame reception, commit and register write next-state logic.
  always_comb begin
    armed_d  = armed_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    live_d   = live_q;
    shadow_d = shadow_q;
    dirty_d  = dirty_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (csb_fall) begin
      armed_d = 1'b1;
      cnt_d   = '0;
      shift_d = '0;
    end else if (armed_q && !csb_s && sclk_rise) begin
      shift_d = {shift_q[FRAME_W-2:0], mosi_s};
      if (cnt_q != CNT_W'(FRAME_W + 1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Commit works from the pre-edge dirty set and shadow contents.
    if (i_commit) begin
      for (int n = 0; n < int'(NUM_REGS); n++) begin
        if (dirty_q[n]) begin
          live_d[n*DATA_W +: DATA_W] = shadow_q[n*DATA_W +: DATA_W];
          dirty_d[n]                 = 1'b0;
        end
      end
    end

    // A same-cycle frame write is applied after commit so it takes priority.
    if (armed_q && csb_rise) begin
      armed_d = 1'b0;
      if (cnt_q == CNT_W'(FRAME_W)) begin
        done_d = 1'b1;
        for (int n = 0; n < int'(NUM_REGS); n++) begin
          if (frame_addr == ADDR_W'(n)) begin
            shadow_d[n*DATA_W +: DATA_W] = frame_data;
            if (i_defer) begin
              dirty_d[n] = 1'b1;
            end else begin
              live_d[n*DATA_W +: DATA_W] = frame_data;
            end
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      csb_sync_q  <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      vld_q       <= '0;
      csb_hist_q  <= 1'b1;
      sclk_hist_q <= 1'b0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      live_q      <= BANK_RESET;
      shadow_q    <= BANK_RESET;
      dirty_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      csb_sync_q  <= csb_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      vld_q       <= vld_d;
      csb_hist_q  <= csb_hist_d;
      sclk_hist_q <= sclk_hist_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      live_q      <= live_d;
      shadow_q    <= shadow_d;
      dirty_q     <= dirty_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Output enable masks the live bank without touching storage.
  assign o_regs       = i_regs_enb ? BANK_RESET : live_q;
  assign o_dirty      = dirty_q;
  assign o_busy       = armed_q;
  assign o_frame_done = done_q;
  assign o_frame_err  = err_q;

endmodule

// File: tb/tb_ew_spi_reg_bank.sv
// Self-checking bench for ew_spi_reg_bank: table of frame/commit vectors plus
// hand sequences for latency, collision, output enable and mid-frame reset.
module tb_ew_spi_reg_bank;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned BANK_W = NREGS * DATA_W;
  localparam int HALF = 6;

  logic              clk, rst;
  logic              csb, sclk, mosi, defer, commit, regs_enb;
  logic [BANK_W-1:0] regs;
  logic [NREGS-1:0]  dirty;
  logic              busy, done, err;

  int nchecks = 0;
  int nerrors = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  ew_spi_reg_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC),
                    .RESET_VALUE(16'h0000)) dut (
    .i_clk(clk), .i_reset(rst), .i_spi_csb(csb), .i_spi_sclk(sclk),
    .i_spi_mosi(mosi), .i_defer(defer), .i_commit(commit),
    .i_regs_enb(regs_enb), .o_regs(regs), .o_dirty(dirty), .o_busy(busy),
    .o_frame_done(done), .o_frame_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err)  err_cnt++;
  end

  typedef struct {
    logic              do_frame;
    logic [31:0]       bits;
    int                nbits;
    logic              defer;
    logic              commit;
    int                exp_done;
    int                exp_err;
    logic [BANK_W-1:0] exp_regs;
    logic [NREGS-1:0]  exp_dirty;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [BANK_W-1:0] act,
                       input logic [BANK_W-1:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      cyc(HALF);
      sclk = 1'b1;
      cyc(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] v, input int n);
    csb = 1'b0;
    cyc(HALF);
    shift_bits(v, n);
    cyc(HALF);
    csb = 1'b1;
    cyc(HALF);
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    cyc(1);
    commit = 1'b0;
    cyc(1);
  endtask

  logic [BANK_W-1:0] e;
  int d0, e0;

  initial begin
    rst = 1'b1; csb = 1'b1; sclk = 1'b0; mosi = 1'b0;
    defer = 1'b0; commit = 1'b0; regs_enb = 1'b0;
    cyc(3);
    check("reset_regs",  regs,  '0);
    check("reset_dirty", BANK_W'(dirty), '0);
    check("reset_busy",  BANK_W'({busy, done, err}), '0);
    rst = 1'b0;
    cyc(3);

    // Immediate write reg5=A5C3 with latency check from raw csb rise.
    e = '0;
    e[5*DATA_W +: DATA_W] = 16'hA5C3;
    d0 = done_cnt;
    csb = 1'b0;
    cyc(HALF);
    shift_bits({13'd0, 3'd5, 16'hA5C3}, 19);
    cyc(HALF);
    check("busy_in_frame", BANK_W'(busy), BANK_W'(1));
    csb = 1'b1;
    cyc(SYNC);
    check("lat_before", regs, '0);
    cyc(1);
    check("lat_at", regs, e);
    check("lat_done_pulse", BANK_W'(done), BANK_W'(1));
    cyc(HALF);
    check("imm_done_count", BANK_W'(done_cnt - d0), BANK_W'(1));
    check("imm_dirty", BANK_W'(dirty), '0);

    // Vector table.
    tbl[0] = '{1'b1, {13'd0, 3'd2, 16'h1234}, 19, 1'b1, 1'b0, 1, 0, e, 8'h04};
    tbl[1] = '{1'b1, {13'd0, 3'd7, 16'hBEEF}, 19, 1'b1, 1'b0, 1, 0, e, 8'h84};
    e[2*DATA_W +: DATA_W] = 16'h1234;
    e[7*DATA_W +: DATA_W] = 16'hBEEF;
    tbl[2] = '{1'b0, 32'd0, 0, 1'b0, 1'b1, 0, 0, e, 8'h00};
    tbl[3] = '{1'b1, 32'h0003FFFF, 18, 1'b0, 1'b0, 0, 1, e, 8'h00};
    tbl[4] = '{1'b1, 32'h000FFFFF, 20, 1'b0, 1'b0, 0, 1, e, 8'h00};
    tbl[5] = '{1'b1, 32'd0, 0, 1'b0, 1'b0, 0, 1, e, 8'h00};
    tbl[6] = '{1'b0, 32'd0, 0, 1'b0, 1'b1, 0, 0, e, 8'h00};
    e[0 +: DATA_W] = 16'hFFFF;
    tbl[7] = '{1'b1, {13'd0, 3'd0, 16'hFFFF}, 19, 1'b0, 1'b0, 1, 0, e, 8'h00};

    for (int i = 0; i < 8; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      defer = tbl[i].defer;
      if (tbl[i].do_frame) send_frame(tbl[i].bits, tbl[i].nbits);
      if (tbl[i].commit) pulse_commit();
      cyc(2);
      check($sformatf("v%0d_done", i), BANK_W'(done_cnt - d0), BANK_W'(tbl[i].exp_done));
      check($sformatf("v%0d_err", i),  BANK_W'(err_cnt - e0),  BANK_W'(tbl[i].exp_err));
      check($sformatf("v%0d_regs", i), regs, tbl[i].exp_regs);
      check($sformatf("v%0d_dirty", i), BANK_W'(dirty), BANK_W'(tbl[i].exp_dirty));
      check($sformatf("v%0d_busy", i), BANK_W'(busy), '0);
    end

    // Collision: deferred frame end coincides with commit.
    defer = 1'b1;
    send_frame({13'd0, 3'd3, 16'h0001}, 19);
    check("col_dirty1", BANK_W'(dirty), BANK_W'(8'h08));
    csb = 1'b0;
    cyc(HALF);
    shift_bits({13'd0, 3'd3, 16'h0002}, 19);
    cyc(HALF);
    csb = 1'b1;
    cyc(SYNC);
    commit = 1'b1;
    cyc(1);
    commit = 1'b0;
    e[3*DATA_W +: DATA_W] = 16'h0001;
    check("col_live_old_shadow", regs, e);
    check("col_dirty_kept", BANK_W'(dirty), BANK_W'(8'h08));
    cyc(HALF);
    pulse_commit();
    e[3*DATA_W +: DATA_W] = 16'h0002;
    check("col_live_second", regs, e);
    check("col_dirty_clear", BANK_W'(dirty), '0);

    // Output enable masks and restores.
    regs_enb = 1'b1;
    cyc(1);
    check("enb_masked", regs, '0);
    regs_enb = 1'b0;
    cyc(1);
    check("enb_restored", regs, e);

    // Reset mid-frame with csb held low across release.
    defer = 1'b0;
    d0 = done_cnt;
    e0 = err_cnt;
    csb = 1'b0;
    cyc(HALF);
    shift_bits({13'd0, 3'd6, 16'h1357}, 10);
    rst = 1'b1;
    cyc(2);
    check("mid_rst_regs", regs, '0);
    check("mid_rst_busy", BANK_W'(busy), '0);
    rst = 1'b0;
    cyc(HALF);
    shift_bits(32'h00000157, 9);
    cyc(HALF);
    check("post_rst_not_armed", BANK_W'(busy), '0);
    csb = 1'b1;
    cyc(HALF + 2);
    check("post_rst_no_done", BANK_W'(done_cnt - d0), '0);
    check("post_rst_no_err", BANK_W'(err_cnt - e0), '0);
    check("post_rst_regs", regs, '0);
    send_frame({13'd0, 3'd1, 16'h5555}, 19);
    e = '0;
    e[1*DATA_W +: DATA_W] = 16'h5555;
    check("post_rst_frame_done", BANK_W'(done_cnt - d0), BANK_W'(1));
    check("post_rst_frame_regs", regs, e);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
